// File: rtl/pzhsbus_deserializer_pkg.sv
// Shared helpers for the pzhsbus deserializer: beat ratio and lane placement.
package pzhsbus_deserializer_pkg;

  function automatic int unsigned calc_ratio(int unsigned master_width,
                                             int unsigned slave_width);
    return (slave_width == 0) ? 0 : master_width / slave_width;
  endfunction

  // Lane that beat number 'counter' occupies inside the wide word.
  function automatic int unsigned get_lane(int unsigned counter, int unsigned ratio,
                                           bit ascending_order);
    return ascending_order ? counter : ratio - 1 - counter;
  endfunction

endpackage

// File: rtl/pzhsbus_deserializer_if.sv
// pzhsbus valid/ready handshake bus with a payload of WIDTH bits.
interface pzhsbus_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] payload;

  modport master (output valid, input ready, output payload);
  modport slave  (input valid, output ready, input payload);
endinterface

// File: rtl/pzhsbus_deserializer_slicer.sv
// Single-stage valid/ready register slice: payload holds while valid && !ready.
module pzbcm_slicer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned STAGES         = 1,
  parameter bit          FULL_BANDWIDTH = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  if ((STAGES != 1) || FULL_BANDWIDTH) begin : g_unsupported
    $error("pzbcm_slicer: only STAGES=1, FULL_BANDWIDTH=0 is implemented");
  end

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign o_ready = !valid_q || i_ready;
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (o_ready) begin
      valid_q <= i_valid;
      if (i_valid) begin
        data_q <= i_data;
      end
    end
  end

endmodule

// File: rtl/pzhsbus_deserializer.sv
// Packs RATIO narrow pzhsbus beats into one wide word.
// Define PZHSBUS_DESERIALIZER_FLUSH_EN to add i_flush (emit a zero-filled partial word).
module pzhsbus_deserializer
  import pzhsbus_deserializer_pkg::*;
#(
  parameter type         SLAVE_PAYLOAD   = logic [7:0],
  parameter type         MASTER_PAYLOAD  = logic [31:0],
  parameter int unsigned RATIO           = calc_ratio($bits(MASTER_PAYLOAD),
                                                      $bits(SLAVE_PAYLOAD)),
  parameter bit          ASCENDING_ORDER = 1'b1,
  parameter bit          FULL_BANDWIDTH  = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
  input  logic      i_flush,
`endif
  pzhsbus_if.slave  slave_if,
  pzhsbus_if.master master_if
);

  localparam int unsigned SW   = $bits(SLAVE_PAYLOAD);
  localparam int unsigned MW   = $bits(MASTER_PAYLOAD);
  localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  if (MW != RATIO * SW) begin : g_bad_width
    $error("pzhsbus_deserializer: master width must equal RATIO * slave width");
  end
  if (RATIO < 2) begin : g_bad_ratio
    $error("pzhsbus_deserializer: RATIO must be at least 2");
  end

  typedef logic [RATIO-1:0][SW-1:0] lanes_t;

  logic [CntW-1:0] cnt_q, cnt_d;
  lanes_t          lanes_q, lanes_d;
  lanes_t          word;
  logic [CntW-1:0] lane;
  logic            rdy_en_q;
  logic            accept, last_beat, flush_req, load, load_ok, base_ready;

`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
  assign flush_req = i_flush && (cnt_q != '0);
`else
  assign flush_req = 1'b0;
`endif

  // A pending flush that cannot load yet blocks new beats until it does.
  assign slave_if.ready = rdy_en_q && base_ready && !(flush_req && !load_ok);

  always_comb begin
    lane      = CntW'(get_lane(32'(cnt_q), RATIO, ASCENDING_ORDER));
    accept    = slave_if.valid && slave_if.ready;
    last_beat = accept && (cnt_q == CntMax);
    // Beat 0 starts from zero so a flushed partial word is zero-filled.
    word      = (cnt_q == '0) ? '0 : lanes_q;
    if (accept) begin
      word[lane] = slave_if.payload;
    end
    load    = last_beat || (flush_req && load_ok);
    lanes_d = accept ? word : lanes_q;
    cnt_d   = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      lanes_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lanes_q  <= lanes_d;
      rdy_en_q <= 1'b1;
    end
  end

  if (FULL_BANDWIDTH) begin : g_full
    pzbcm_slicer #(
      .WIDTH          (MW),
      .STAGES         (1),
      .FULL_BANDWIDTH (1'b0)
    ) u_slicer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (load),
      .o_ready (load_ok),
      .i_data  (word),
      .o_valid (master_if.valid),
      .i_ready (master_if.ready),
      .o_data  (master_if.payload)
    );

    assign base_ready = (cnt_q != CntMax) || load_ok;
  end else begin : g_shared
    logic valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (master_if.ready) begin
        valid_q <= 1'b0;
      end
    end

    assign load_ok           = !valid_q;
    assign base_ready        = !valid_q;
    assign master_if.valid   = valid_q;
    assign master_if.payload = lanes_q;
  end

endmodule

// File: tb/tb_pzhsbus_deserializer.sv
// Directed bench: ascending/descending full-bandwidth instances plus a shared-buffer instance.
module tb_pzhsbus_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sv, mr, fsv, fmr, fl;
  logic [7:0] sp, fsp;

  pzhsbus_if #(.WIDTH(8))  s_a ();
  pzhsbus_if #(.WIDTH(32)) m_a ();
  pzhsbus_if #(.WIDTH(8))  s_d ();
  pzhsbus_if #(.WIDTH(32)) m_d ();
  pzhsbus_if #(.WIDTH(8))  s_f ();
  pzhsbus_if #(.WIDTH(32)) m_f ();

  assign s_a.valid   = sv;
  assign s_a.payload = sp;
  assign m_a.ready   = mr;
  assign s_d.valid   = sv;
  assign s_d.payload = sp;
  assign m_d.ready   = mr;
  assign s_f.valid   = fsv;
  assign s_f.payload = fsp;
  assign m_f.ready   = fmr;

  pzhsbus_deserializer #(.ASCENDING_ORDER(1'b1), .FULL_BANDWIDTH(1'b1)) u_dut_a (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
    .i_flush   (fl),
`endif
    .slave_if  (s_a),
    .master_if (m_a)
  );

  pzhsbus_deserializer #(.ASCENDING_ORDER(1'b0), .FULL_BANDWIDTH(1'b1)) u_dut_d (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
    .i_flush   (fl),
`endif
    .slave_if  (s_d),
    .master_if (m_d)
  );

  pzhsbus_deserializer #(.ASCENDING_ORDER(1'b1), .FULL_BANDWIDTH(1'b0)) u_dut_f (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
    .i_flush   (1'b0),
`endif
    .slave_if  (s_f),
    .master_if (m_f)
  );

  logic [31:0] qa[$], qd[$], qf[$];
  int unsigned n_total = 0, n_pass = 0;
  int          ready_lo_a = 0, ready_lo_f = 0;

  always @(posedge clk) begin
    if (m_a.valid && m_a.ready) qa.push_back(m_a.payload);
    if (m_d.valid && m_d.ready) qd.push_back(m_d.payload);
    if (m_f.valid && m_f.ready) qf.push_back(m_f.payload);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a beat on the a/d inputs until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    logic acc = 1'b0;
    int   n   = 0;
    sv = 1'b1;
    sp = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_a.ready;
      if (!acc) ready_lo_a++;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_f(input logic [7:0] b);
    logic acc = 1'b0;
    int   n   = 0;
    fsv = 1'b1;
    fsp = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = s_f.ready;
      if (!acc) ready_lo_f++;
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("send_f_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    sv = 1'b0; sp = '0; mr = 1'b0;
    fsv = 1'b0; fsp = '0; fmr = 1'b0;
    fl = 1'b0;

    // Reset
    tick(2);
    check_eq("rst_ready_in_reset", 32'(s_a.ready), 32'd0);
    check_eq("rst_valid", 32'(m_a.valid), 32'd0);
    check_eq("rst_payload", m_a.payload, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check_eq("rst_ready_after", 32'(s_a.ready), 32'd1);
    check_eq("rst_f_ready_after", 32'(s_f.ready), 32'd1);
    check_eq("rst_f_valid", 32'(m_f.valid), 32'd0);

    // Basic word, both lane orders
    mr = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    sv = 1'b0;
    check_eq("basic_valid", 32'(m_a.valid), 32'd1);
    check_eq("basic_asc", m_a.payload, 32'h44332211);
    check_eq("basic_desc", m_d.payload, 32'h11223344);
    tick(2);
    check_eq("basic_handoff_valid", 32'(m_a.valid), 32'd0);
    check_eq("basic_q_size", 32'(qa.size()), 32'd1);
    check_eq("basic_q_word", qa[0], 32'h44332211);
    qa.delete(); qd.delete();

    // Sustained stream at full bandwidth
    ready_lo_a = 0;
    for (int i = 0; i < 16; i++) send(8'(i));
    sv = 1'b0;
    tick(2);
    check_eq("stream_ready_never_low", 32'(ready_lo_a), 32'd0);
    check_eq("stream_q_size", 32'(qa.size()), 32'd4);
    check_eq("stream_asc_w0", qa[0], 32'h03020100);
    check_eq("stream_asc_w3", qa[3], 32'h0F0E0D0C);
    check_eq("stream_desc_w0", qd[0], 32'h00010203);
    check_eq("stream_desc_w3", qd[3], 32'h0C0D0E0F);
    qa.delete(); qd.delete();

    // Backpressure: word held, gather stops before the last beat
    mr = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(i));
    sv = 1'b1; sp = 8'h07;
    #1;
    check_eq("bp_ready_low", 32'(s_a.ready), 32'd0);
    check_eq("bp_valid", 32'(m_a.valid), 32'd1);
    check_eq("bp_hold_asc", m_a.payload, 32'h03020100);
    check_eq("bp_hold_desc", m_d.payload, 32'h00010203);
    tick(3);
    check_eq("bp_hold_asc_later", m_a.payload, 32'h03020100);
    check_eq("bp_ready_still_low", 32'(s_a.ready), 32'd0);
    mr = 1'b1;
    #1;
    check_eq("bp_ready_release", 32'(s_a.ready), 32'd1);
    tick(1);
    sv = 1'b0;
    check_eq("bp_valid_kept", 32'(m_a.valid), 32'd1);
    check_eq("bp_next_asc", m_a.payload, 32'h07060504);
    check_eq("bp_next_desc", m_d.payload, 32'h04050607);
    tick(2);
    check_eq("bp_q_size", 32'(qa.size()), 32'd2);
    check_eq("bp_q_w0", qa[0], 32'h03020100);
    check_eq("bp_q_w1", qa[1], 32'h07060504);
    qa.delete(); qd.delete();

    // Reset mid-word discards partial beats
    send(8'hAA); send(8'hBB);
    sv = 1'b0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    check_eq("midrst_valid", 32'(m_a.valid), 32'd0);
    tick(1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    sv = 1'b0;
    check_eq("midrst_valid_after", 32'(m_a.valid), 32'd1);
    check_eq("midrst_asc", m_a.payload, 32'h04030201);
    check_eq("midrst_desc", m_d.payload, 32'h01020304);
    tick(2);
    qa.delete(); qd.delete();

    // Shared-buffer instance: ready drops one cycle per word
    fmr = 1'b1;
    ready_lo_f = 0;
    for (int i = 0; i < 4; i++) send_f(8'(i));
    check_eq("fb0_valid", 32'(m_f.valid), 32'd1);
    check_eq("fb0_word0", m_f.payload, 32'h03020100);
    for (int i = 4; i < 8; i++) send_f(8'(i));
    fsv = 1'b0;
    tick(2);
    check_eq("fb0_ready_low_cycles", 32'(ready_lo_f), 32'd1);
    check_eq("fb0_q_size", 32'(qf.size()), 32'd2);
    check_eq("fb0_q_w0", qf[0], 32'h03020100);
    check_eq("fb0_q_w1", qf[1], 32'h07060504);

`ifdef PZHSBUS_DESERIALIZER_FLUSH_EN
    // Flush of a partial word, then a flush with nothing gathered
    send(8'hAA); send(8'hBB);
    sv = 1'b0;
    fl = 1'b1;
    tick(1);
    fl = 1'b0;
    check_eq("flush_valid", 32'(m_a.valid), 32'd1);
    check_eq("flush_asc", m_a.payload, 32'h0000BBAA);
    check_eq("flush_desc", m_d.payload, 32'hAABB0000);
    tick(2);
    check_eq("flush_q_size", 32'(qa.size()), 32'd1);
    qa.delete(); qd.delete();
    fl = 1'b1;
    tick(2);
    fl = 1'b0;
    check_eq("flush_empty_valid", 32'(m_a.valid), 32'd0);
    check_eq("flush_empty_q", 32'(qa.size()), 32'd0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    sv = 1'b0;
    check_eq("flush_after_word", m_a.payload, 32'h04030201);
    tick(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
